// File: rtl/hilbert_pkg.sv
// rtl/hilbert_pkg.sv - shared defaults and round/saturate helper for Hilbert output taps
package hilbert_pkg;

    localparam int DEF_ACC_W = 24;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_SHIFT = 8;
    localparam int DEF_DEPTH = 4;

    // Working width of round_sat; callers sign-extend into it and take the low OUT_W bits.
    localparam int MAX_W = 64;

    typedef struct packed {
        logic                    sat;
        logic signed [MAX_W-1:0] value;
    } rs_t;

    // Round-half-up, arithmetic shift, then clamp to a signed out_w range.
    function automatic rs_t round_sat(
        input logic signed [MAX_W-1:0] acc,
        input int                      shift,
        input int                      out_w
    );
        logic signed [MAX_W-1:0] half;
        logic signed [MAX_W-1:0] sum;
        logic signed [MAX_W-1:0] scaled;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        rs_t                     r;
        half   = 64'sd1 <<< (shift - 1);
        sum    = acc + half;
        scaled = sum >>> shift;
        hi     = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo     = -(64'sd1 <<< (out_w - 1));
        r.sat   = 1'b0;
        r.value = scaled;
        if (scaled > hi) begin
            r.sat   = 1'b1;
            r.value = hi;
        end else if (scaled < lo) begin
            r.sat   = 1'b1;
            r.value = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - circular result buffer with push/pop, occupancy and drop reporting
module result_fifo
    import hilbert_pkg::*;
#(
    parameter int W     = DEF_OUT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   push_ok,
    output logic                   drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [LW-1:0] level_next;
    logic          do_pop;

    assign valid   = (level != '0);
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push_ok = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign rdata   = valid ? mem[rptr] : '0;

    always_comb begin
        level_next = level;
        case ({push_ok, do_pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            full  <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
        end
    end

endmodule

// File: rtl/hilbert_out_stage.sv
// rtl/hilbert_out_stage.sv - round/saturate SOT capture, result queue and sticky status
module hilbert_out_stage
    import hilbert_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   done,
    input  logic [ACC_W-1:0]       sot,
    input  logic                   out_ready,
    input  logic                   clr_flags,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic                   sat,
    output logic [15:0]            frame_cnt
);

    logic [MAX_W-1:0] sot_ext;
    rs_t              rs;
    logic             unused_hi;
    logic             s1_vld;
    logic [OUT_W-1:0] s1_data;
    logic             push_ok;
    logic             drop;

    assign sot_ext = {{(MAX_W-ACC_W){sot[ACC_W-1]}}, sot};

    always_comb begin
        rs = round_sat(sot_ext, SHIFT, OUT_W);
    end

    // After the clamp the upper bits are only sign extension.
    assign unused_hi = ^rs.value[MAX_W-1:OUT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_vld <= done;
            if (done) begin
                s1_data <= rs.value[OUT_W-1:0];
            end
        end
    end

    result_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s1_vld),
        .pop     (out_ready),
        .wdata   (s1_data),
        .rdata   (out_data),
        .valid   (out_valid),
        .level   (level),
        .full    (full),
        .push_ok (push_ok),
        .drop    (drop)
    );

    // Set has priority over clear so an event coinciding with clr_flags is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat       <= 1'b0;
            ovf       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (done && rs.sat) begin
                sat <= 1'b1;
            end else if (clr_flags) begin
                sat <= 1'b0;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_flags) begin
                ovf <= 1'b0;
            end
            if (push_ok) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
